// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared line geometry, AXI constants and writeback state type
package dcache_pkg;

  localparam int LINE_WORDS  = 8;
  localparam int OFFSET_BITS = 5;
  localparam int WORD_IDX_W  = $clog2(LINE_WORDS);

  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {IDLE, READ, AW, W, B} wb_state_e;

endpackage

// File: rtl/dcache_line_buf.sv
// rtl/dcache_line_buf.sv - one-line staging buffer between the data RAM and the W channel
module dcache_line_buf
  import dcache_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORD_IDX_W-1:0] widx,
  input  logic [31:0]           wdata,
  input  logic [WORD_IDX_W-1:0] ridx,
  output logic [31:0]           rdata
);

  logic [31:0] mem [LINE_WORDS];

  // capture one returned RAM word per READ cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dcache_writeback.sv
// rtl/dcache_writeback.sv - dirty-line eviction engine; DCACHE_WB_BRESP_CHECK_EN enables sticky bresp error
module dcache_writeback
  import dcache_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_req,
  input  logic [31:0] wb_addr,
  output logic        wb_busy,
  output logic        wb_done,
  output logic        wb_err,
  output logic        ram_en,
  output logic [31:0] ram_addr,
  input  logic [31:0] ram_rdata,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int                    BEAT_LAST_I = LINE_WORDS - 1;
  localparam logic [WORD_IDX_W-1:0] BEAT_LAST   = BEAT_LAST_I[WORD_IDX_W-1:0];
  localparam logic [WORD_IDX_W-1:0] BEAT_ONE    = 1;
  localparam logic [WORD_IDX_W:0]   RCNT_LAST   = LINE_WORDS[WORD_IDX_W:0];
  localparam logic [WORD_IDX_W:0]   RCNT_ONE    = 1;
  localparam logic [7:0]            AWLEN       = BEAT_LAST_I[7:0];

  wb_state_e             state, state_nxt;
  logic [31:0]           base;
  logic [WORD_IDX_W:0]   rcnt;
  logic [WORD_IDX_W:0]   rcnt_m1;
  logic [WORD_IDX_W-1:0] beat;
  logic                  read_last;
  logic                  buf_we;
  logic [31:0]           buf_rdata;

  // rcnt runs 0..LINE_WORDS; the extra cycle drains the last RAM word
  assign read_last = (rcnt == RCNT_LAST);
  assign rcnt_m1   = rcnt - RCNT_ONE;
  assign buf_we    = (state == READ) && (rcnt != '0);

  dcache_line_buf u_buf (
    .clk   (clk),
    .we    (buf_we),
    .widx  (rcnt_m1[WORD_IDX_W-1:0]),
    .wdata (ram_rdata),
    .ridx  (beat),
    .rdata (buf_rdata)
  );

  assign awid    = AXI_ID;
  assign wid     = AXI_ID;
  assign awlen   = AWLEN;
  assign awsize  = SIZE_4B;
  assign awburst = BURST_INCR;
  assign wstrb   = 4'hF;
  assign awaddr  = base;
  assign wdata   = buf_rdata;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wb_req) state_nxt = READ;
      READ:    if (read_last) state_nxt = AW;
      AW:      if (awready) state_nxt = W;
      W:       if (wready && (beat == BEAT_LAST)) state_nxt = B;
      B:       if (bvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // per-state outputs; RAM address is zero whenever the read port is idle
  always_comb begin
    ram_en   = 1'b0;
    ram_addr = '0;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    wlast    = 1'b0;
    bready   = 1'b0;
    wb_busy  = (state != IDLE);
    case (state)
      READ: begin
        ram_en = ~read_last;
        if (!read_last) begin
          ram_addr = base + {{(30 - WORD_IDX_W - 1){1'b0}}, rcnt, 2'b00};
        end
      end
      AW: awvalid = 1'b1;
      W: begin
        wvalid = 1'b1;
        wlast  = (beat == BEAT_LAST);
      end
      B:       bready = 1'b1;
      default: ;
    endcase
  end

  // line base latch, RAM read counter and W beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      base <= '0;
      rcnt <= '0;
      beat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wb_req) begin
            base <= {wb_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            rcnt <= '0;
            beat <= '0;
          end
        end
        READ:    rcnt <= rcnt + RCNT_ONE;
        W:       if (wready) beat <= beat + BEAT_ONE;
        default: ;
      endcase
    end
  end

  // completion pulse in the cycle after the B handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_done <= 1'b0;
    end else begin
      wb_done <= (state == B) && bvalid;
    end
  end

`ifdef DCACHE_WB_BRESP_CHECK_EN
  // sticky error on any non-OKAY write response, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_err <= 1'b0;
    end else if ((state == B) && bvalid && (bresp != RESP_OKAY)) begin
      wb_err <= 1'b1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{bid, wb_addr[OFFSET_BITS-1:0]};
`else
  assign wb_err = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{bid, bresp, wb_addr[OFFSET_BITS-1:0]};
`endif

endmodule
